// File: rtl/tag_alloc.sv
// Round-robin free-list allocator for W tags; offers the free tag nearest below the pointer (circular).
// Optional sticky protocol checker enabled by defining TAG_ALLOC_CHECK_EN.
module tag_alloc #(
  parameter int W = 16,
  parameter bit INFER = 1'b0,
  localparam int LW = $clog2(W),
  localparam int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_i,
  output logic          alloc_rdy_o,
  output logic [LW-1:0] alloc_tag_o,
  input  logic          free_vld_i,
  input  logic [LW-1:0] free_tag_i,
  input  logic          flush_i,
  output logic [W-1:0]  busy_o,
  output logic [CW-1:0] cnt_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          err_o
);

  if (W < 2) begin : g_bad_w
    $error("tag_alloc: W must be at least 2");
  end

  localparam logic [LW:0] W_L = (LW + 1)'(W);

  logic [W-1:0]  busy_r, busy_n;
  logic [LW-1:0] ptr_r, ptr_n;
  logic [CW-1:0] cnt_r, cnt_n;
  logic [LW-1:0] cand;

  logic fire;
  logic free_ok;
  logic busy_at_free;
  logic dec;

  // Candidate search; both variants examine ptr-1 down to 0, then W-1 down to ptr.
  if (INFER) begin : g_rot
    logic [2*W-1:0] dbl;
    logic [W-1:0]   rot;
    logic [LW:0]    off;
    logic [LW:0]    sum;

    always_comb begin
      dbl = {busy_r, busy_r};
      rot = W'(dbl >> ptr_r);
      off = '0;
      for (int j = 0; j < W; j++) begin
        if (!rot[j]) off = (LW + 1)'(j);
      end
      sum = {1'b0, ptr_r} + off;
      if (sum >= W_L) sum = sum - W_L;
      cand = LW'(sum);
    end
  end else begin : g_pos
    logic [W-1:0]  free_v;
    logic [W-1:0]  below;
    logic [W-1:0]  free_lo;
    logic [LW-1:0] cand_lo;
    logic [LW-1:0] cand_all;

    for (genvar t = 0; t < W; t++) begin : g_below
      assign below[t] = (LW'(t) < ptr_r);
    end

    assign free_v  = ~busy_r;
    assign free_lo = free_v & below;

    always_comb begin
      cand_lo  = '0;
      cand_all = '0;
      for (int i = 0; i < W; i++) begin
        if (free_lo[i]) cand_lo = LW'(i);
        if (free_v[i])  cand_all = LW'(i);
      end
      cand = (|free_lo) ? cand_lo : cand_all;
    end
  end

  assign alloc_rdy_o = ~(&busy_r) & ~flush_i;
  assign alloc_tag_o = cand;
  assign fire        = alloc_i & alloc_rdy_o;

  // Tags >= W only exist when W is not a power of two; such frees are ignored.
  assign free_ok      = ({1'b0, free_tag_i} < W_L);
  assign busy_at_free = free_ok & busy_r[free_tag_i];
  // The offered tag is always free, so only a release of a busy tag lowers the count.
  assign dec          = free_vld_i & busy_at_free;

  always_comb begin
    busy_n = busy_r;
    ptr_n  = ptr_r;
    cnt_n  = cnt_r + CW'(fire) - CW'(dec);
    if (free_vld_i && free_ok) busy_n[free_tag_i] = 1'b0;
    if (fire) begin
      busy_n[alloc_tag_o] = 1'b1;
      ptr_n               = alloc_tag_o;
    end
    if (flush_i) begin
      busy_n = '0;
      ptr_n  = '0;
      cnt_n  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= '0;
      ptr_r  <= '0;
      cnt_r  <= '0;
    end else begin
      busy_r <= busy_n;
      ptr_r  <= ptr_n;
      cnt_r  <= cnt_n;
    end
  end

`ifdef TAG_ALLOC_CHECK_EN
  logic err_r;
  logic same_tag;
  logic err_set;

  assign same_tag = fire & (free_tag_i == alloc_tag_o);
  assign err_set  = (free_vld_i & ~busy_at_free & ~same_tag)
                  | (free_vld_i & same_tag)
                  | (alloc_i & ~alloc_rdy_o & ~flush_i);

  // Sticky until reset; flush deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (rst)          err_r <= 1'b0;
    else if (err_set) err_r <= 1'b1;
  end

  assign err_o = err_r;
`else
  assign err_o = 1'b0;
`endif

  assign busy_o  = busy_r;
  assign cnt_o   = cnt_r;
  assign full_o  = (cnt_r == CW'(W));
  assign empty_o = (cnt_r == '0);

endmodule

// File: tb/tb_tag_alloc.sv
// Scoreboard bench for tag_alloc (W=4): both search variants run side by side against hand-computed expectations.
module tb_tag_alloc;

`ifdef TAG_ALLOC_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alloc = 1'b0;
  logic       free_vld = 1'b0;
  logic [1:0] free_tag = '0;
  logic       flush = 1'b0;

  logic       rdy_a, rdy_b, full_a, full_b, empty_a, empty_b, err_a, err_b;
  logic [1:0] tag_a, tag_b;
  logic [3:0] busy_a, busy_b;
  logic [2:0] cnt_a, cnt_b;

  tag_alloc #(.W(4), .INFER(1'b0)) dut_pos (
    .clk(clk), .rst(rst), .alloc_i(alloc), .alloc_rdy_o(rdy_a), .alloc_tag_o(tag_a),
    .free_vld_i(free_vld), .free_tag_i(free_tag), .flush_i(flush), .busy_o(busy_a),
    .cnt_o(cnt_a), .full_o(full_a), .empty_o(empty_a), .err_o(err_a)
  );

  tag_alloc #(.W(4), .INFER(1'b1)) dut_rot (
    .clk(clk), .rst(rst), .alloc_i(alloc), .alloc_rdy_o(rdy_b), .alloc_tag_o(tag_b),
    .free_vld_i(free_vld), .free_tag_i(free_tag), .flush_i(flush), .busy_o(busy_b),
    .cnt_o(cnt_b), .full_o(full_b), .empty_o(empty_b), .err_o(err_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm;
    int    rdy;   // -1 = don't care
    int    tag;   // -1 = don't care
    int    busy;
    int    cnt;
    int    err;
  } exp_t;

  exp_t q[$];
  int   gq[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   err_exp = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic check_set(input string nm, input exp_t e, input logic rdy, input logic [1:0] tag,
                           input logic [3:0] busy, input logic [2:0] cnt, input logic full,
                           input logic empty, input logic err);
    if (e.rdy >= 0) chk({nm, "_rdy"}, 32'(rdy), 32'(e.rdy));
    if (e.tag >= 0) chk({nm, "_tag"}, 32'(tag), 32'(e.tag));
    chk({nm, "_busy"}, 32'(busy), 32'(e.busy));
    chk({nm, "_cnt"}, 32'(cnt), 32'(e.cnt));
    chk({nm, "_full"}, 32'(full), 32'(e.cnt == 4));
    chk({nm, "_empty"}, 32'(empty), 32'(e.cnt == 0));
    chk({nm, "_err"}, 32'(err), 32'(e.err));
  endtask

  // Monitor: pops one expectation per cycle and checks every grant that fires.
  always @(negedge clk) begin
    if (!rst) begin
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check_set({e.nm, "_pos"}, e, rdy_a, tag_a, busy_a, cnt_a, full_a, empty_a, err_a);
        check_set({e.nm, "_rot"}, e, rdy_b, tag_b, busy_b, cnt_b, full_b, empty_b, err_b);
      end
      if (alloc && (rdy_a || rdy_b)) begin
        if (gq.size() == 0) begin
          chk("unexpected_grant", 32'(tag_a), 32'hffff_ffff);
        end else begin
          int g;
          g = gq.pop_front();
          chk("grant_rdy_pos", 32'(rdy_a), 32'd1);
          chk("grant_rdy_rot", 32'(rdy_b), 32'd1);
          chk("grant_tag_pos", 32'(tag_a), 32'(g));
          chk("grant_tag_rot", 32'(tag_b), 32'(g));
        end
      end
    end
  end

  task automatic drive(input bit a, input bit fv, input logic [1:0] ft, input bit fl);
    alloc    = a;
    free_vld = fv;
    free_tag = ft;
    flush    = fl;
  endtask

  task automatic expect_out(input string nm, input int rdy, input int tag, input int busy, input int cnt);
    exp_t e;
    e.nm = nm; e.rdy = rdy; e.tag = tag; e.busy = busy; e.cnt = cnt; e.err = int'(err_exp);
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit a, input bit fv, input logic [1:0] ft, input bit fl);
    drive(a, fv, ft, fl);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    err_exp = 1'b0;
    drive(0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Fill the pool: grants 3,2,1,0.
    drive(1, 0, 0, 0); expect_out("t1_g3", 1, 3, 4'b0000, 0); gq.push_back(3); tick();
    expect_out("t1_g2", 1, 2, 4'b1000, 1); gq.push_back(2); tick();
    expect_out("t1_g1", 1, 1, 4'b1100, 2); gq.push_back(1); tick();
    expect_out("t1_g0", 1, 0, 4'b1110, 3); gq.push_back(0); tick();
    drive(0, 0, 0, 0); expect_out("t1_full", 0, -1, 4'b1111, 4); tick();

    // Full pool, free 2 with alloc requested: no fire, tag 2 offered next.
    drive(1, 1, 2, 0); expect_out("t3_fullfree", 0, -1, 4'b1111, 4); tick();
    err_exp = CHK;
    drive(0, 0, 0, 0); expect_out("t3_offer2", 1, 2, 4'b1011, 3); tick();

    // Freed tag is not re-offered ahead of the pointer order.
    do_reset(1, 1, 2, 1);
    drive(1, 0, 0, 0); expect_out("t2_g3", 1, 3, 4'b0000, 0); gq.push_back(3); tick();
    expect_out("t2_g2", 1, 2, 4'b1000, 1); gq.push_back(2); tick();
    drive(0, 1, 3, 0); expect_out("t2_free3", 1, 1, 4'b1100, 2); tick();
    drive(1, 0, 0, 0); expect_out("t2_g1", 1, 1, 4'b0100, 1); gq.push_back(1); tick();
    drive(0, 0, 0, 0); expect_out("t2_after", 1, 0, 4'b0110, 2); tick();

    // Build busy=0011, ptr=1; then alloc tag 3 with simultaneous free of tag 0.
    do_reset(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    gq.push_back(3); tick(); gq.push_back(2); tick(); gq.push_back(1); tick(); gq.push_back(0); tick();
    drive(0, 1, 1, 0); expect_out("t4_free1", 0, -1, 4'b1111, 4); tick();
    drive(1, 0, 0, 0); expect_out("t4_offer1", 1, 1, 4'b1101, 3); gq.push_back(1); tick();
    drive(0, 1, 3, 0); expect_out("t4_full2", 0, -1, 4'b1111, 4); tick();
    drive(0, 1, 2, 0); expect_out("t4_free2", 1, 3, 4'b0111, 3); tick();
    drive(1, 1, 0, 0); expect_out("t4_pre", 1, 3, 4'b0011, 2); gq.push_back(3); tick();
    drive(0, 0, 0, 0); expect_out("t4_post", 1, 2, 4'b1010, 2); tick();

    // Flush with alloc requested at cnt=3.
    drive(1, 0, 0, 0); expect_out("t5_g2", 1, 2, 4'b1010, 2); gq.push_back(2); tick();
    drive(1, 0, 0, 1); expect_out("t5_flush", 0, -1, 4'b1110, 3); tick();
    drive(0, 0, 0, 0); expect_out("t5_after", 1, 3, 4'b0000, 0); tick();

    // Release of a free tag: count unchanged; error sticky through flush, cleared by reset.
    drive(0, 1, 1, 0); expect_out("t6_badfree", 1, 3, 4'b0000, 0); tick();
    err_exp = CHK;
    drive(0, 0, 0, 0); expect_out("t6_err", 1, 3, 4'b0000, 0); tick();
    drive(0, 0, 0, 1); expect_out("t6_flushcyc", 0, -1, 4'b0000, 0); tick();
    drive(0, 0, 0, 0); expect_out("t6_keep", 1, 3, 4'b0000, 0); tick();
    do_reset(1, 1, 2, 0);
    expect_out("t6_rst", 1, 3, 4'b0000, 0); tick();

    @(negedge clk);
    #1;
    chk("grants_left", 32'(gq.size()), 32'd0);
    chk("exp_left", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
